// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and the GF(2^8) xtime helper.
package aes_pkg;

    localparam int unsigned AES_KEY_W  = 128;
    localparam int unsigned AES_WORD_W = 32;
    localparam int unsigned AES_NR     = 10;

    localparam logic [7:0] AES_RCON_INIT = 8'h01;
    localparam logic [7:0] AES_RPOLY     = 8'h1b;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ks_state_e;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? AES_RPOLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] x,
    output logic [7:0] sub_c
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign sub_c = SBOX[x];

endmodule

// File: rtl/key_schedule128.sv
// Iterative AES-128 key expansion: emits round keys 0..NR, one per accepted handshake.
module key_schedule128
    import aes_pkg::*;
#(
    parameter int unsigned NR = AES_NR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AES_KEY_W-1:0] key_in,
    input  logic                 key_ready,
    output logic [AES_KEY_W-1:0] round_key,
    output logic [3:0]           round_idx,
    output logic                 key_valid,
    output logic                 busy,
    output logic                 done
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    ks_state_e              state_q, state_d;
    logic [7:0]             rcon_q, rcon_d;
    logic [AES_KEY_W-1:0]   round_key_d;
    logic [3:0]             round_idx_d;
    logic                   key_valid_d, busy_d, done_d;

    logic [AES_WORD_W-1:0]  w0, w1, w2, w3;
    logic [AES_WORD_W-1:0]  rot_w, sub_w, t_w;
    logic [AES_WORD_W-1:0]  n0, n1, n2, n3;
    logic                   xfer;

    // Next round key from the current one.
    assign {w0, w1, w2, w3} = round_key;
    assign rot_w = {w3[23:0], w3[31:24]};

    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
        aes_sbox u_sbox (
            .x     (rot_w[gi*8 +: 8]),
            .sub_c (sub_w[gi*8 +: 8])
        );
    end

    assign t_w = sub_w ^ {rcon_q, 24'h0};
    assign n0  = w0 ^ t_w;
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;

    assign xfer = key_valid & key_ready;

    // Next-state and next-output decode.
    always_comb begin
        state_d     = state_q;
        rcon_d      = rcon_q;
        round_key_d = round_key;
        round_idx_d = round_idx;
        key_valid_d = key_valid;
        busy_d      = busy;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    rcon_d      = AES_RCON_INIT;
                    round_key_d = key_in;
                    round_idx_d = 4'd0;
                    key_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            RUN: begin
                if (xfer) begin
                    if (round_idx == LAST_IDX) begin
                        state_d     = IDLE;
                        key_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        round_key_d = {n0, n1, n2, n3};
                        round_idx_d = round_idx + 4'd1;
                        rcon_d      = xtime(rcon_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rcon_q    <= AES_RCON_INIT;
            round_key <= '0;
            round_idx <= 4'd0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rcon_q    <= rcon_d;
            round_key <= round_key_d;
            round_idx <= round_idx_d;
            key_valid <= key_valid_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_key_schedule128.sv
// Scoreboard bench for key_schedule128 with an independent GF(2^8) key-expansion model.
`timescale 1ns/1ps
module tb_key_schedule128;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_ready = 1'b1;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid, busy, done;

    key_schedule128 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .key_ready (key_ready),
        .round_key (round_key),
        .round_idx (round_idx),
        .key_valid (key_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    exp_t         exp_q[$];
    logic [7:0]   tb_sbox [256];
    logic [7:0]   rcon_tbl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [127:0] rk_seen [16];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           done_cnt = 0;
    int           start_cyc;

    // Count a comparison and report any mismatch.
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box built from the multiplicative inverse plus the affine map.
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            tb_sbox[x] = s;
        end
    endtask

    function automatic logic [127:0] model_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] a0, a1, a2, a3, t;
        {a0, a1, a2, a3} = k;
        t  = {tb_sbox[a3[23:16]], tb_sbox[a3[15:8]], tb_sbox[a3[7:0]], tb_sbox[a3[31:24]]}
             ^ {rc, 24'h0};
        a0 = a0 ^ t;
        a1 = a1 ^ a0;
        a2 = a2 ^ a1;
        a3 = a3 ^ a2;
        return {a0, a1, a2, a3};
    endfunction

    task automatic push_run(input logic [127:0] key);
        exp_t e;
        logic [127:0] k = key;
        for (int i = 0; i <= 10; i++) begin
            e.idx = 4'(i);
            e.key = k;
            exp_q.push_back(e);
            if (i < 10) k = model_next(k, rcon_tbl[i]);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Pop and compare on every accepted key; count done pulses.
    always @(negedge clk) begin
        exp_t e;
        if (done) done_cnt++;
        if (!rst && key_valid && key_ready) begin
            if (exp_q.size() == 0) begin
                check("unexp_xfer", 128'(round_idx), 128'hf);
            end else begin
                e = exp_q.pop_front();
                check("xfer_idx", 128'(round_idx), 128'(e.idx));
                check("xfer_key", round_key, e.key);
            end
            rk_seen[round_idx] = round_key;
        end
    end

    // Assert start for one cycle; returns with round 0 visible.
    task automatic start_run(input logic [127:0] key);
        @(posedge clk); #1;
        push_run(key);
        key_in    = key;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_idx(input logic [3:0] idx);
        int n = 0;
        while (!(key_valid && round_idx == idx) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 60) check("tmo_idx", 128'(round_idx), 128'(idx));
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 80) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 80) check("tmo_done", 128'(done), 128'h1);
    endtask

    initial begin
        logic [127:0] hold_key;
        int           dc0;

        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        check("rst_key", round_key, 128'h0);
        check("rst_idx", 128'(round_idx), 128'h0);
        check("rst_valid", 128'(key_valid), 128'h0);
        check("rst_busy", 128'(busy), 128'h0);
        check("rst_done", 128'(done), 128'h0);
        rst = 1'b0;

        // FIPS-197 key, ready tied high
        dc0 = done_cnt;
        start_run(FIPS_KEY);
        check("r0_key", round_key, FIPS_KEY);
        check("r0_busy", 128'(busy), 128'h1);
        wait_done();
        check("done_lat", 128'(cyc - start_cyc), 128'd12);
        check("done_valid", 128'(key_valid), 128'h0);
        check("done_busy", 128'(busy), 128'h0);
        check("done_hold_idx", 128'(round_idx), 128'd10);
        check("fips_r1", rk_seen[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("fips_r2", rk_seen[2], 128'hf2c295f27a96b9435935807a7359f67f);
        check("fips_r10", rk_seen[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        @(posedge clk); #1;
        check("done_pulse", 128'(done), 128'h0);
        check("done_once", 128'(done_cnt - dc0), 128'h1);

        // All-zero key
        start_run(128'h0);
        wait_done();
        check("zero_r1", rk_seen[1], 128'h62636363626363636263636362636363);
        check("zero_r10", rk_seen[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Backpressure for 5 cycles at round 3
        start_run(FIPS_KEY);
        wait_idx(4'd3);
        key_ready = 1'b0;
        hold_key  = round_key;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_idx", 128'(round_idx), 128'd3);
            check("bp_key", round_key, hold_key);
        end
        key_ready = 1'b1;
        wait_done();
        check("bp_r10", rk_seen[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // start while busy is ignored
        start_run(FIPS_KEY);
        wait_idx(4'd5);
        start  = 1'b1;
        key_in = ALT_KEY;
        @(posedge clk); #1;
        start = 1'b0;
        check("sb_busy", 128'(busy), 128'h1);
        wait_done();
        check("sb_r10", rk_seen[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Reset in the middle of a run
        start_run(ALT_KEY);
        wait_idx(4'd4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mr_key", round_key, 128'h0);
        check("mr_idx", 128'(round_idx), 128'h0);
        check("mr_valid", 128'(key_valid), 128'h0);
        check("mr_busy", 128'(busy), 128'h0);
        check("mr_done", 128'(done), 128'h0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("mr_quiet", 128'(key_valid), 128'h0);
        start_run(FIPS_KEY);
        wait_done();
        check("mr_r10", rk_seen[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Back-to-back: start accepted in the done cycle
        check("b2b_empty", 128'(exp_q.size()), 128'h0);
        push_run(ALT_KEY);
        key_in = ALT_KEY;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        key_in = '0;
        check("b2b_valid", 128'(key_valid), 128'h1);
        check("b2b_idx", 128'(round_idx), 128'h0);
        check("b2b_key", round_key, ALT_KEY);
        wait_done();
        @(posedge clk); #1;
        check("end_empty", 128'(exp_q.size()), 128'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_schedule128.md
Name: key_schedule128

Overview:
- Iterative AES-128 key expansion stage that sits directly upstream of addRoundKey128.
- Accepts a 128-bit cipher key and produces round keys 0..10 in order, one per accepted handshake.
- Each round key goes on the key input of addRoundKey128.
- One round key is computed per cycle from the previous one, so no 11-entry key store is needed.

Parameters:
- NR, 10, number of rounds; round_idx runs 0..NR. Fixed at 10 for AES-128; other values are unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  load key_in and begin expansion; honoured only in IDLE.
- key_in  input  128  cipher key; key_in[127:96] = w0, key_in[31:0] = w3.
- key_ready  input  1  consumer accepts round_key this cycle.
- round_key  output  128  current round key, same word order as key_in.
- round_idx  output  4  index of round_key (0..10).
- key_valid  output  1  round_key/round_idx valid.
- busy  output  1  high from start acceptance until the last key is accepted.
- done  output  1  one-cycle pulse after round key 10 is accepted.

Behaviour:
- Reset: state=IDLE; round_key=0, round_idx=0, key_valid=0, busy=0, done=0; rcon register=8'h01.
- States: IDLE, RUN.
- IDLE, start=1:
  - next cycle round_key=key_in, round_idx=0, key_valid=1, busy=1, rcon=01.
  - state goes to RUN.
  - Latency from start to first valid key is 1 cycle.
- RUN, key_valid and key_ready both high (transfer), round_idx<10:
  - next cycle round_key=next key, round_idx+1, key_valid stays 1.
  - rcon advances by xtime: 01,02,04,08,10,20,40,80,1b,36.
- Next key, for current words w0..w3:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
- RUN, transfer with round_idx=10:
  - next cycle key_valid=0, busy=0, done=1 for one cycle.
  - state goes to IDLE.
  - round_key and round_idx hold their last values.
- Backpressure: key_valid=1 and key_ready=0 holds round_key, round_idx and rcon stable indefinitely. The consumer may stall at any round.
- start while busy is ignored; the key in progress is not disturbed.
- start in the same cycle as the final transfer (done not yet asserted) is ignored. start is accepted in IDLE, including the cycle done is high.
- key_in is sampled only on the accepting cycle; later changes have no effect.
- rst mid-operation returns everything to reset values on the next edge. No partial key is emitted afterwards.
- rcon is internal 8-bit state. xtime: {r[6:0],1'b0} ^ (r[7] ? 8'h1b : 8'h00).

Decomposition:
- Shared package aes_pkg:
  - constants AES_KEY_W=128, AES_WORD_W=32, AES_NR=10.
  - rcon initial value 8'h01 and reduction polynomial 8'h1b.
  - state encoding IDLE/RUN.
- Sub-module aes_sbox: combinational 8-in/8-out S-box. Four instances form SubWord; the same module is reused by the subBytes stage.
- The next-key function stays inline in key_schedule128.

Test Plan:
- FIPS-197 key, key_ready tied high:
  - key_in=2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle.
  - Round 0 equals key_in.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 2 = f2c295f27a96b9435935807a7359f67f.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done pulses once, exactly 12 cycles after start.
- All-zero key:
  - Round 1 = 62636363626363636263636362636363.
  - Round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure on the FIPS-197 key:
  - key_ready held low 5 cycles at round_idx=3.
  - round_key and round_idx stable throughout; remaining sequence identical to the first scenario.
- start while busy:
  - pulse start with a different key_in at round_idx=5.
  - Sequence continues unchanged from the original key; busy stays 1.
- Reset mid-run:
  - rst at round_idx=4.
  - Next cycle all outputs are 0.
  - A new start then produces the full correct sequence beginning at round 0.
- Back-to-back runs:
  - start asserted in the done cycle is accepted.
  - Second run's round 0 is valid the following cycle.
